// File: rtl/dummy_accelerator_dispatch.sv
// Dispatch front end: issues requests to N_UNITS in-order execution units and
// returns their results strictly in issue order through a small tracking FIFO.
module dummy_accelerator_dispatch #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 11,
  parameter int TAG_WIDTH = 8,
  parameter int N_UNITS   = 4,
  parameter int DEPTH     = 8,
  parameter int CTL_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [CTL_WIDTH-1:0]          ctl_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [WIDTH-1:0]              rs1_value_i,
  input  logic [IMM_WIDTH-1:0]          imm_i,
  input  logic [TAG_WIDTH-1:0]          tag_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WIDTH-1:0]              result_o,
  output logic [TAG_WIDTH-1:0]          tag_o,
  output logic                          err_o,
  output logic [$clog2(DEPTH+1)-1:0]    outstanding_o,
  output logic [N_UNITS-1:0]            unit_valid_o,
  input  logic [N_UNITS-1:0]            unit_ready_i,
  output logic [WIDTH-1:0]              unit_rs1_o,
  output logic [IMM_WIDTH-1:0]          unit_imm_o,
  output logic [TAG_WIDTH-1:0]          unit_tag_o,
  output logic                          unit_flush_o,
  input  logic [N_UNITS-1:0]            unit_valid_i,
  output logic [N_UNITS-1:0]            unit_ready_o,
  input  logic [N_UNITS*WIDTH-1:0]      unit_result_i,
  input  logic [N_UNITS*TAG_WIDTH-1:0]  unit_tag_i
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int UIDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam logic [CTL_WIDTH:0] N_UNITS_L = (CTL_WIDTH + 1)'(N_UNITS);

  typedef struct packed {
    logic                 illegal;
    logic [UIDX_W-1:0]    unit;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              idle, full, empty, req_legal, head_live, push, pop;
  logic [N_UNITS-1:0] req_sel, head_sel;
  entry_t            head;
  logic [WIDTH-1:0]  head_result;
  logic [TAG_WIDTH-1:0] head_tag;
  logic              head_unit_valid;

  // Reset and flush both freeze every handshake for the cycle they are high.
  assign idle      = rst_i | flush_i;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign req_legal = ({1'b0, ctl_i} < N_UNITS_L);
  assign head      = fifo_q[rd_ptr_q];
  assign head_live = !idle && !empty;

  for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_sel
    assign req_sel[gi]  = (ctl_i == CTL_WIDTH'(gi));
    assign head_sel[gi] = (head.unit == UIDX_W'(gi));
  end

  always_comb begin
    head_result     = '0;
    head_tag        = '0;
    head_unit_valid = 1'b0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (head_sel[k]) begin
        head_result     = unit_result_i[k*WIDTH +: WIDTH];
        head_tag        = unit_tag_i[k*TAG_WIDTH +: TAG_WIDTH];
        head_unit_valid = unit_valid_i[k];
      end
    end
  end

  assign ready_o      = !idle && !full && (!req_legal || |(req_sel & unit_ready_i));
  assign unit_valid_o = (!idle && valid_i && !full && req_legal) ? req_sel : '0;
  assign unit_rs1_o   = rs1_value_i;
  assign unit_imm_o   = imm_i;
  assign unit_tag_o   = tag_i;
  assign unit_flush_o = idle;

  // Illegal heads complete on their own; legal heads wait for their unit.
  assign valid_o      = head_live && (head.illegal || head_unit_valid);
  assign err_o        = head_live && head.illegal;
  assign result_o     = (head_live && !head.illegal) ? head_result : '0;
  assign tag_o        = !head_live ? '0 : (head.illegal ? head.tag : head_tag);
  assign unit_ready_o = (head_live && !head.illegal && ready_i) ? head_sel : '0;
  assign outstanding_o = count_q;

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{illegal: !req_legal, unit: ctl_i[UIDX_W-1:0], tag: tag_i};
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: doc/dummy_accelerator_dispatch.md
Name: dummy_accelerator_dispatch

Overview:
- Next-generation execution-unit front end for the dummy accelerator subsystem.
- Routes each CPU request to one of N_UNITS external in-order execution units, selected by ctl_i.
- Records the issuing unit in an in-order tracking FIFO and returns results strictly in issue order.
- Consecutive requests may target different units and may have differing latencies; there is no software ordering constraint and no fixed-pipe-length assumption.

Parameters:
- WIDTH, 32, data width of operand and result.
- IMM_WIDTH, 11, immediate width, forwarded unchanged to the units.
- TAG_WIDTH, 8, request tag width (rd/id from the X-interface).
- N_UNITS, 4, number of attached execution units (1..16).
- DEPTH, 8, maximum in-flight requests (power of two, at least 2).
- CTL_WIDTH, 4, width of ctl_i; must satisfy 2**CTL_WIDTH >= N_UNITS.

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset. One clock; reset is synchronous and active-high.
- flush_i in 1: synchronous flush; discards all in-flight tracking.
- ctl_i in CTL_WIDTH: target unit index.
- valid_i in 1: upstream request valid.
- ready_o out 1: request accepted this cycle.
- rs1_value_i in WIDTH: operand.
- imm_i in IMM_WIDTH: immediate.
- tag_i in TAG_WIDTH: request tag.
- valid_o out 1: result valid to downstream.
- ready_i in 1: downstream ready.
- result_o out WIDTH: result.
- tag_o out TAG_WIDTH: result tag.
- err_o out 1: qualifies valid_o; set when the request targeted an illegal unit.
- outstanding_o out clog2(DEPTH+1): in-flight count.
- unit_valid_o out N_UNITS: per-unit request valid.
- unit_ready_i in N_UNITS: per-unit request ready.
- unit_rs1_o out WIDTH: operand broadcast to all units.
- unit_imm_o out IMM_WIDTH: immediate broadcast to all units.
- unit_tag_o out TAG_WIDTH: tag broadcast to all units.
- unit_flush_o out 1: flush_i forwarded to all units.
- unit_valid_i in N_UNITS: per-unit result valid.
- unit_ready_o out N_UNITS: per-unit result ready.
- unit_result_i in N_UNITS*WIDTH: packed per-unit results; unit k occupies bits [k*WIDTH +: WIDTH].
- unit_tag_i in N_UNITS*TAG_WIDTH: packed per-unit result tags.

Behaviour:
- Tracking FIFO:
  - DEPTH entries, each holding {illegal flag, unit index, tag}.
  - Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - Count register is clog2(DEPTH+1) bits.
  - full = (count == DEPTH); empty = (count == 0).
- Legal request (ctl_i < N_UNITS):
  - ready_o = !full && unit_ready_i[ctl_i].
  - unit_valid_o[ctl_i] = valid_i && !full; all other unit_valid_o bits are 0.
- Illegal request (ctl_i >= N_UNITS):
  - ready_o = !full; no unit is issued.
  - The entry is pushed with illegal=1 and stores tag_i.
- Push occurs on valid_i && ready_o.
- ready_o must not depend on same-cycle pop: a full FIFO refuses requests even while popping.
- Head output when not empty:
  - Legal head (unit h): valid_o = unit_valid_i[h]; result_o and tag_o are unit h's values; unit_ready_o[h] = ready_i; all other unit_ready_o bits are 0.
  - Illegal head: valid_o = 1, err_o = 1, result_o = 0, tag_o = stored tag; no unit handshake.
- When empty: valid_o = 0, err_o = 0, result_o = 0, tag_o = 0, and unit_ready_o = 0.
- Pop occurs on valid_o && ready_i.
- unit_valid_i from units other than the head unit is ignored (held off by unit_ready_o = 0).
- Latency:
  - No same-cycle bypass: a request accepted at cycle t can produce valid_o no earlier than t+1.
  - An illegal request produces valid_o at exactly t+1 when the FIFO is otherwise empty.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal when count is between 1 and DEPTH-1 inclusive.
- Unit ordering: each unit must return its results in its own issue order; cross-unit ordering is enforced here.
- Flush:
  - unit_flush_o = flush_i, combinationally.
  - On flush_i: pointers and count are cleared at the next edge; ready_o = 0, valid_o = 0, and all unit_valid_o and unit_ready_o bits are 0 during the flush cycle.
  - Flush has priority over push and pop.
- Reset (rst_i = 1 at an edge, including mid-operation):
  - Pointers, count, and FIFO contents clear.
  - After reset: valid_o = 0, err_o = 0, result_o = 0, tag_o = 0, outstanding_o = 0, ready_o = 0 (all handshake outputs are 0 while rst_i is high), unit_valid_o = 0, unit_ready_o = 0.
  - unit_flush_o = rst_i || flush_i.
- outstanding_o equals count (registered).

Test Plan:
- Single request, ctl=2, unit 2 responds 3 cycles later with 0xDEAD_BEEF, tag 0x11 -> valid_o for one cycle, result_o=0xDEADBEEF, tag_o=0x11, outstanding_o 1->0.
- ctl=0 (latency 5) then ctl=1 (latency 1), tags 0xA0 and 0xA1 -> unit 1 is held off until unit 0's result pops; outputs in order A0 then A1.
- 8 requests with all units ready and ready_i=0 -> ready_o drops after the 8th request, outstanding_o=8; a 9th request waits until a pop occurs, then is accepted the following cycle.
- ctl=7 with N_UNITS=4, tag 0x3C, FIFO empty -> no unit_valid_o asserted; next cycle valid_o=1, err_o=1, result_o=0, tag_o=0x3C.
- Three requests in flight, then flush_i pulse -> unit_flush_o high in the same cycle, outstanding_o=0 the next cycle, valid_o=0; a new request is then accepted normally.
- rst_i asserted mid-burst with 5 in flight -> all outputs return to reset values at the next edge; traffic resumes cleanly after release.
